// File: rtl/frame_verifier_pkg.sv
// Shared types and helpers for the frame verifier.
//   err_t   : result code reported on out_err.
//   state_t : control FSM states of frame_verifier.
//   n_chunk : number of TAG_W-wide chunks covering the frame body.
package frame_verifier_pkg;

  typedef enum logic [1:0] {
    ERR_OK     = 2'd0,
    ERR_TAG    = 2'd1,
    ERR_WINDOW = 2'd2,
    ERR_REPLAY = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HASH  = 2'd1,
    CHECK = 2'd2,
    OUT   = 2'd3
  } state_t;

  // ceil((msg_w - tag_w) / tag_w)
  function automatic int n_chunk(input int msg_w, input int tag_w);
    return (msg_w - tag_w + tag_w - 1) / tag_w;
  endfunction

endpackage

// File: rtl/frame_verifier_fold_tag_engine.sv
// Keyed fold tag engine: folds the frame body into a TAG_W accumulator,
// one chunk per cycle: acc <= rotl1(acc) ^ chunk[idx].
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load KEY and begin folding (ignored while busy)
//   body         : frame body, must stay stable while busy
//   busy         : folding in progress
//   done         : high in the cycle the last chunk is being folded
//   tag          : accumulator value (final once busy has fallen)
module fold_tag_engine
  import frame_verifier_pkg::*;
#(
  parameter int              BODY_W = 216,
  parameter int              TAG_W  = 40,
  parameter logic [TAG_W-1:0] KEY   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BODY_W-1:0] body,
  output logic              busy,
  output logic              done,
  output logic [TAG_W-1:0]  tag
);

  localparam int N_CHUNK = n_chunk(BODY_W + TAG_W, TAG_W);
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CHUNK - 1);

  logic [N_CHUNK*TAG_W-1:0] body_ext;
  logic [TAG_W-1:0]         acc;
  logic [TAG_W-1:0]         chunk;
  logic [IDX_W-1:0]         idx;

  // Body is zero-extended up to a whole number of chunks.
  always_comb begin
    body_ext                = '0;
    body_ext[BODY_W-1:0]    = body;
    chunk                   = body_ext[int'(idx)*TAG_W +: TAG_W];
  end

  assign done = busy && (idx == LAST);
  assign tag  = acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      idx  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      acc  <= KEY;
      idx  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= {acc[TAG_W-2:0], acc[TAG_W-1]} ^ chunk;
      if (idx == LAST) busy <= 1'b0;
      else             idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/frame_verifier.sv
// Frame verifier: accepts a {timestamp, payload, tag} frame, recomputes the
// keyed fold tag, checks the timestamp window and replay, and returns the
// payload with a pass/error status. Keeps saturating pass/fail counters.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_frame/now_ts/threshold
//   out_valid/out_ready   : output handshake, out_payload/out_pass/out_err
//   cnt_pass, cnt_fail    : saturating statistics
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; a source holds valid and data until that edge, ready never
// depends combinationally on valid.
module frame_verifier
  import frame_verifier_pkg::*;
#(
  parameter int               MSG_W     = 256,
  parameter int               TS_W      = 32,
  parameter int               TAG_W     = 40,
  parameter int               THR_W     = 10,
  parameter int               CNT_W     = 16,
  parameter logic [TAG_W-1:0] KEY       = 40'h5A5A5A5A5A,
  parameter bit               REPLAY_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MSG_W-1:0]       in_frame,
  input  logic [TS_W-1:0]        now_ts,
  input  logic [THR_W-1:0]       threshold,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MSG_W-TAG_W-1:0] out_payload,
  output logic                   out_pass,
  output logic [1:0]             out_err,
  output logic [CNT_W-1:0]       cnt_pass,
  output logic [CNT_W-1:0]       cnt_fail
);

  localparam int BODY_W = MSG_W - TAG_W;
  localparam logic [TS_W:0] TS_MAX = {1'b0, {TS_W{1'b1}}};

  state_t            state;
  logic [MSG_W-1:0]  frame_q;
  logic [TS_W-1:0]   now_q;
  logic [THR_W-1:0]  thr_q;
  logic [TS_W-1:0]   last_ts;
  logic              last_vld;

  logic              start;
  logic              eng_busy;
  logic              eng_done;
  logic [TAG_W-1:0]  eng_tag;

  logic [TS_W-1:0]   ts;
  logic [TS_W:0]     now_w, thr_w, ts_w, lo, hi;
  err_t              err_next;

  assign ts    = frame_q[MSG_W-1 -: TS_W];
  assign start = (state == IDLE) && in_valid && in_ready && !eng_busy;

  fold_tag_engine #(
    .BODY_W (BODY_W),
    .TAG_W  (TAG_W),
    .KEY    (KEY)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .body    (frame_q[MSG_W-1:TAG_W]),
    .busy    (eng_busy),
    .done    (eng_done),
    .tag     (eng_tag)
  );

  // Window bounds are formed one bit wider so now-thr and now+thr can be
  // clamped instead of wrapping.
  always_comb begin
    now_w              = {1'b0, now_q};
    ts_w               = {1'b0, ts};
    thr_w              = '0;
    thr_w[THR_W-1:0]   = thr_q;
    lo                 = (now_w >= thr_w) ? (now_w - thr_w) : '0;
    hi                 = now_w + thr_w;
    if (hi > TS_MAX) hi = TS_MAX;

    err_next = ERR_OK;
    if (eng_tag != frame_q[TAG_W-1:0])            err_next = ERR_TAG;
    else if ((ts_w < lo) || (ts_w > hi))          err_next = ERR_WINDOW;
    else if (REPLAY_EN && last_vld && (ts <= last_ts)) err_next = ERR_REPLAY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_pass    <= 1'b0;
      out_err     <= ERR_OK;
      frame_q     <= '0;
      now_q       <= '0;
      thr_q       <= '0;
      last_ts     <= '0;
      last_vld    <= 1'b0;
      cnt_pass    <= '0;
      cnt_fail    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frame_q  <= in_frame;
            now_q    <= now_ts;
            thr_q    <= threshold;
            in_ready <= 1'b0;
            state    <= HASH;
          end
        end
        HASH: begin
          if (eng_done) state <= CHECK;
        end
        CHECK: begin
          out_err   <= err_next;
          out_valid <= 1'b1;
          if (err_next == ERR_OK) begin
            out_payload <= frame_q[MSG_W-1:TAG_W];
            out_pass    <= 1'b1;
            last_ts     <= ts;
            last_vld    <= 1'b1;
            if (cnt_pass != '1) cnt_pass <= cnt_pass + 1'b1;
          end else begin
            out_payload <= '0;
            out_pass    <= 1'b0;
            if (cnt_fail != '1) cnt_fail <= cnt_fail + 1'b1;
          end
          state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_verifier.sv
// Directed bench for frame_verifier. Instance a uses KEY=0 with replay
// checking; instance b uses the default KEY with replay checking off.
module tb_frame_verifier;

  localparam int MSG_W = 256;
  localparam int TS_W  = 32;
  localparam int TAG_W = 40;
  localparam int THR_W = 10;
  localparam int CNT_W = 16;
  localparam logic [TAG_W-1:0] KEY_DEF = 40'h5A5A5A5A5A;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid_a = 1'b0, in_valid_b = 1'b0, out_ready = 1'b1;
  logic [MSG_W-1:0]   in_frame = '0;
  logic [TS_W-1:0]    now_ts = '0;
  logic [THR_W-1:0]   threshold = '0;

  logic               in_ready_a, out_valid_a, out_pass_a;
  logic [215:0]       out_payload_a;
  logic [1:0]         out_err_a;
  logic [CNT_W-1:0]   cnt_pass_a, cnt_fail_a;
  logic               in_ready_b, out_valid_b, out_pass_b;
  logic [215:0]       out_payload_b;
  logic [1:0]         out_err_b;
  logic [CNT_W-1:0]   cnt_pass_b, cnt_fail_b;

  frame_verifier #(.KEY('0), .REPLAY_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_frame(in_frame), .now_ts(now_ts), .threshold(threshold),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_payload(out_payload_a),
    .out_pass(out_pass_a), .out_err(out_err_a), .cnt_pass(cnt_pass_a), .cnt_fail(cnt_fail_a)
  );

  frame_verifier #(.REPLAY_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_frame(in_frame), .now_ts(now_ts), .threshold(threshold),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_payload(out_payload_b),
    .out_pass(out_pass_b), .out_err(out_err_b), .cnt_pass(cnt_pass_b), .cnt_fail(cnt_fail_b)
  );

  // selected instance view
  logic sel_b = 1'b0;
  logic m_in_ready, m_out_valid, m_out_pass;
  logic [215:0] m_payload;
  logic [1:0] m_err;
  logic [CNT_W-1:0] m_cnt_pass, m_cnt_fail;
  assign m_in_ready  = sel_b ? in_ready_b    : in_ready_a;
  assign m_out_valid = sel_b ? out_valid_b   : out_valid_a;
  assign m_out_pass  = sel_b ? out_pass_b    : out_pass_a;
  assign m_payload   = sel_b ? out_payload_b : out_payload_a;
  assign m_err       = sel_b ? out_err_b     : out_err_a;
  assign m_cnt_pass  = sel_b ? cnt_pass_b    : cnt_pass_a;
  assign m_cnt_fail  = sel_b ? cnt_fail_b    : cnt_fail_a;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int exp_pass[2];
  int exp_fail[2];

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [31:0] ts, input logic [183:0] mid,
                                      input logic [39:0] tag);
    return {ts, mid, tag};
  endfunction

  // Reference fold: acc = key; for each 40-bit chunk of the zero-extended body,
  // acc = rotl1(acc) ^ chunk.
  function automatic logic [39:0] fold(input logic [39:0] key, input logic [215:0] body);
    logic [239:0] ext;
    logic [39:0]  acc;
    ext = '0;
    ext[215:0] = body;
    acc = key;
    for (int k = 0; k < 6; k++) acc = {acc[38:0], acc[39]} ^ ext[k*40 +: 40];
    return acc;
  endfunction

  function automatic logic [255:0] good(input logic [39:0] key, input logic [31:0] ts,
                                        input logic [183:0] mid);
    return mk(ts, mid, fold(key, {ts, mid}));
  endfunction

  task automatic check_a_cleared(input string name);
    check({name, " in_ready"},  in_ready_a,    1);
    check({name, " out_valid"}, out_valid_a,   0);
    check({name, " payload"},   out_payload_a, 0);
    check({name, " pass"},      out_pass_a,    0);
    check({name, " err"},       out_err_a,     0);
    check({name, " cnt_pass"},  cnt_pass_a,    0);
    check({name, " cnt_fail"},  cnt_fail_a,    0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    out_ready = 1'b1;
    #1;
    check_a_cleared("reset_a");
    check("reset_b in_ready", in_ready_b, 1);
    check("reset_b cnt_pass", cnt_pass_b, 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_pass[0] = 0; exp_fail[0] = 0;
    exp_pass[1] = 0; exp_fail[1] = 0;
  endtask

  // Drive a frame from a falling edge and return just after the accepting edge.
  task automatic offer(input bit b, input string name, input logic [255:0] frame,
                       input logic [31:0] now, input logic [9:0] thr);
    bit got;
    sel_b = b;
    @(negedge clk);
    in_frame = frame; now_ts = now; threshold = thr;
    if (b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      got = m_in_ready;
      @(posedge clk);
      if (got) break;
      @(negedge clk);
    end
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    // Late changes to the time inputs must not affect the frame in flight.
    now_ts = $urandom;
    threshold = 10'($urandom_range(0, 1023));
    check({name, " accepted"}, got, 1);
  endtask

  // Count edges after the accepting edge until out_valid. Counting the
  // accepting edge itself as edge 1, out_valid shows on edge 8 at the
  // default sizes, i.e. 7 edges after it.
  task automatic wait_out(input string name);
    int e;
    e = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (m_out_valid) begin e = i; break; end
    end
    check({name, " latency"}, e, 7);
    check({name, " in_ready_busy"}, m_in_ready, 0);
  endtask

  task automatic check_result(input string name, input bit b, input logic [255:0] frame,
                              input bit exp_ok, input logic [1:0] exp_err);
    if (exp_ok) exp_pass[b]++; else exp_fail[b]++;
    check({name, " pass"},     m_out_pass, exp_ok);
    check({name, " err"},      m_err, exp_err);
    check({name, " payload"},  m_payload, exp_ok ? frame[255:40] : 216'h0);
    check({name, " cnt_pass"}, m_cnt_pass, exp_pass[b]);
    check({name, " cnt_fail"}, m_cnt_fail, exp_fail[b]);
  endtask

  task automatic run(input bit b, input string name, input logic [255:0] frame,
                     input logic [31:0] now, input logic [9:0] thr,
                     input bit exp_ok, input logic [1:0] exp_err);
    offer(b, name, frame, now, thr);
    wait_out(name);
    check_result(name, b, frame, exp_ok, exp_err);
    @(posedge clk); #1;
    check({name, " out_valid_clr"}, m_out_valid, 0);
    check({name, " in_ready_back"}, m_in_ready, 1);
  endtask

  localparam logic [183:0] MID = 184'hDEADBEEF_0123456789ABCDEF_CAFEF00D_55AA33CC;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [255:0] f1, f2;

    do_reset();

    // Hand-computed tags with KEY=0: zero body folds to 0.
    run(0, "sat_lo",  mk(32'd0, 184'h0, 40'h0), 32'd5, 10'd10, 1'b1, 2'd0);
    do_reset();
    // Only chunk 0 bit 0 set: 1 rotated 5 more times -> 0x20.
    run(0, "chunk0",  mk(32'd0, 184'h1, 40'h20), 32'd0, 10'd0, 1'b1, 2'd0);
    do_reset();
    // ts bit 16 is chunk 5 bit 0, folded last -> 0x1.
    run(0, "chunk5",  mk(32'h10000, 184'h0, 40'h1), 32'h10000, 10'd0, 1'b1, 2'd0);
    run(0, "tag_bad", mk(32'h10001, 184'h0, 40'h1), 32'h10001, 10'd0, 1'b0, 2'd1);
    // Tag (real 0x5) and window both bad: tag error wins.
    run(0, "tag_prio", mk(32'h50000, 184'h0, 40'h3), 32'd0, 10'd10, 1'b0, 2'd1);

    // Window edges around now=1000, thr=10.
    do_reset();
    run(0, "win_990",  good('0, 32'd990,  MID), 32'd1000, 10'd10, 1'b1, 2'd0);
    run(0, "win_1011", good('0, 32'd1011, MID), 32'd1000, 10'd10, 1'b0, 2'd2);
    run(0, "win_1010", good('0, 32'd1010, MID), 32'd1000, 10'd10, 1'b1, 2'd0);

    // Replay against last accepted timestamp.
    do_reset();
    run(0, "rp_first", good('0, 32'd1000, MID), 32'd1000, 10'd10, 1'b1, 2'd0);
    run(0, "rp_again", good('0, 32'd1000, MID), 32'd1000, 10'd10, 1'b0, 2'd3);
    run(0, "rp_next",  good('0, 32'd1001, MID), 32'd1000, 10'd10, 1'b1, 2'd0);
    run(0, "sat_hi",   good('0, 32'hFFFFFFFF, MID), 32'hFFFFFFF8, 10'd10, 1'b1, 2'd0);

    // Default KEY, replay disabled: zero body folds to rotl6(KEY).
    run(1, "nr_key",   mk(32'd0, 184'h0, 40'h9696969696), 32'd0, 10'd0, 1'b1, 2'd0);
    run(1, "nr_same",  mk(32'd0, 184'h0, 40'h9696969696), 32'd0, 10'd0, 1'b1, 2'd0);
    run(1, "nr_1000a", good(KEY_DEF, 32'd1000, MID), 32'd1000, 10'd10, 1'b1, 2'd0);
    run(1, "nr_1000b", good(KEY_DEF, 32'd1000, MID), 32'd1000, 10'd10, 1'b1, 2'd0);

    // Backpressure on instance a.
    do_reset();
    f1 = good('0, 32'd2000, MID);
    f2 = good('0, 32'd2001, ~MID);
    out_ready = 1'b0;
    offer(0, "bp_f1", f1, 32'd2000, 10'd5);
    wait_out("bp_f1");
    check_result("bp_f1", 0, f1, 1'b1, 2'd0);
    in_frame = f2; now_ts = 32'd2001; threshold = 10'd5;
    in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold valid",    out_valid_a, 1);
      check("bp_hold payload",  out_payload_a, f1[255:40]);
      check("bp_hold err",      out_err_a, 0);
      check("bp_hold in_ready", in_ready_a, 0);
      check("bp_hold cnt_pass", cnt_pass_a, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release valid", out_valid_a, 0);
    check("bp_release in_ready", in_ready_a, 1);
    @(posedge clk); #1;
    check("bp_f2 accepted", in_ready_a, 0);
    in_valid_a = 1'b0;
    wait_out("bp_f2");
    check_result("bp_f2", 0, f2, 1'b1, 2'd0);
    @(posedge clk); #1;

    // Reset in the middle of HASH (idx=3) aborts the frame.
    offer(0, "rst_mid", good('0, 32'd3000, MID), 32'd3000, 10'd5);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_a_cleared("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    exp_pass[0] = 0; exp_fail[0] = 0;
    @(negedge clk);
    check_a_cleared("rst_mid_after");
    run(0, "post_rst", good('0, 32'd3000, MID), 32'd3000, 10'd5, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
